// File: rtl/r_type_exec_if.sv
// Instruction handshake plus register-file port bundle
// seen by the R-type execute/write-back sequencer.
interface r_type_exec_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);
  logic              inst_valid;
  logic [31:0]       inst;
  logic              inst_ready;
  logic [ADDR_W-1:0] raddra;
  logic [ADDR_W-1:0] raddrb;
  logic [DATA_W-1:0] douta;
  logic [DATA_W-1:0] doutb;
  logic              wea;
  logic [ADDR_W-1:0] waddra;
  logic [DATA_W-1:0] dina;
  logic              done;
  logic              illegal;
  logic              zf;
  logic              of;

  modport master (
    output inst_valid, inst, douta, doutb,
    input  inst_ready, raddra, raddrb, wea,
    input  waddra, dina, done, illegal, zf, of
  );

  modport slave (
    input  inst_valid, inst, douta, doutb,
    output inst_ready, raddra, raddrb, wea,
    output waddra, dina, done, illegal, zf, of
  );
endinterface

// File: rtl/r_type_exec.sv
// Four-state execute/write-back sequencer for R-type
// instructions sitting in front of a 32x32 register file.
module r_type_exec #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic          clka,
  input  logic          rsta,
  r_type_exec_if.slave  bus
);
  typedef enum logic [1:0] {
    IDLE, READ, EXEC, WB
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] rs_q, rs_d;
  logic [ADDR_W-1:0] rt_q, rt_d;
  logic [ADDR_W-1:0] rd_q, rd_d;
  logic [4:0]        sh_q, sh_d;
  logic [5:0]        fn_q, fn_d;
  logic [DATA_W-1:0] a_q, a_d;
  logic [DATA_W-1:0] b_q, b_d;
  logic [DATA_W-1:0] res_q, res_d;
  logic              zf_q, zf_d;
  logic              of_q, of_d;
  logic              ill_q, ill_d;
  logic [DATA_W-1:0] alu;
  logic              alu_of;
  logic              accept;
  logic              legal;

  localparam int MSB = DATA_W - 1;

  function automatic logic supported(
    input logic [5:0] f
  );
    case (f)
      6'h20, 6'h22, 6'h24, 6'h25,
      6'h26, 6'h27, 6'h2A, 6'h00,
      6'h02:   supported = 1'b1;
      default: supported = 1'b0;
    endcase
  endfunction

  assign bus.inst_ready = (state_q == IDLE) && !rsta;
  assign accept = bus.inst_valid && bus.inst_ready;
  assign legal  = (bus.inst[31:26] == 6'd0)
               && supported(bus.inst[5:0]);

  always_comb begin
    alu    = '0;
    alu_of = 1'b0;
    case (fn_q)
      6'h20: begin
        alu    = a_q + b_q;
        alu_of = (a_q[MSB] == b_q[MSB])
              && (alu[MSB] != a_q[MSB]);
      end
      6'h22: begin
        alu    = a_q - b_q;
        alu_of = (a_q[MSB] != b_q[MSB])
              && (alu[MSB] != a_q[MSB]);
      end
      6'h24:   alu = a_q & b_q;
      6'h25:   alu = a_q | b_q;
      6'h26:   alu = a_q ^ b_q;
      6'h27:   alu = ~(a_q | b_q);
      6'h2A:   alu = {{(DATA_W-1){1'b0}},
                      $signed(a_q) < $signed(b_q)};
      6'h00:   alu = b_q << sh_q;
      6'h02:   alu = b_q >> sh_q;
      default: alu = '0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    rs_d    = rs_q;
    rt_d    = rt_q;
    rd_d    = rd_q;
    sh_d    = sh_q;
    fn_d    = fn_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    zf_d    = zf_q;
    of_d    = of_q;
    ill_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept && legal) begin
          rs_d    = bus.inst[25:21];
          rt_d    = bus.inst[20:16];
          rd_d    = bus.inst[15:11];
          sh_d    = bus.inst[10:6];
          fn_d    = bus.inst[5:0];
          state_d = READ;
        end else if (accept) begin
          ill_d = 1'b1;
        end
      end
      READ: begin
        a_d     = bus.douta;
        b_d     = bus.doutb;
        state_d = EXEC;
      end
      EXEC: begin
        res_d   = alu;
        zf_d    = (alu == '0);
        of_d    = alu_of;
        state_d = WB;
      end
      WB:      state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clka) begin
    if (rsta) begin
      state_q <= IDLE;
      rs_q    <= '0;
      rt_q    <= '0;
      rd_q    <= '0;
      sh_q    <= '0;
      fn_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      zf_q    <= 1'b0;
      of_q    <= 1'b0;
      ill_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      rs_q    <= rs_d;
      rt_q    <= rt_d;
      rd_q    <= rd_d;
      sh_q    <= sh_d;
      fn_q    <= fn_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      zf_q    <= zf_d;
      of_q    <= of_d;
      ill_q   <= ill_d;
    end
  end

  // Register 0 is hardwired: write-back completes but never writes it.
  assign bus.wea     = (state_q == WB) && (rd_q != '0);
  assign bus.done    = (state_q == WB);
  assign bus.raddra  = rs_q;
  assign bus.raddrb  = rt_q;
  assign bus.waddra  = rd_q;
  assign bus.dina    = res_q;
  assign bus.illegal = ill_q;
  assign bus.zf      = zf_q;
  assign bus.of      = of_q;
endmodule

// File: tb/tb_r_type_exec.sv
// Directed bench for r_type_exec with a behavioural
// 32x32 register file attached to its ports.
module tb_r_type_exec;
  logic clk = 1'b0;
  logic rsta;
  int   errors = 0;
  int   checks = 0;

  logic [31:0] rf [32];
  logic        pre_we = 1'b0;
  logic [4:0]  pre_a  = '0;
  logic [31:0] pre_d  = '0;

  always #5 clk = ~clk;

  r_type_exec_if #(.DATA_W(32), .ADDR_W(5)) bus ();

  r_type_exec #(.DATA_W(32), .ADDR_W(5)) dut (
    .clka (clk),
    .rsta (rsta),
    .bus  (bus.slave)
  );

  always_comb begin
    bus.douta = (bus.raddra == 5'd0) ? 32'd0 : rf[bus.raddra];
    bus.doutb = (bus.raddrb == 5'd0) ? 32'd0 : rf[bus.raddrb];
  end

  always @(posedge clk) begin
    if (pre_we) rf[pre_a] <= pre_d;
    else if (bus.wea) rf[bus.waddra] <= bus.dina;
  end

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic preload(input logic [4:0] a,
                         input logic [31:0] d);
    @(negedge clk);
    pre_we = 1'b1;
    pre_a  = a;
    pre_d  = d;
    @(posedge clk);
    #1 pre_we = 1'b0;
  endtask

  task automatic exec_op(input string tag,
                         input logic [31:0] ins,
                         input logic [31:0] exp_d,
                         input logic exp_z,
                         input logic exp_o);
    logic [4:0] rd;
    rd = ins[15:11];
    @(negedge clk);
    bus.inst       = ins;
    bus.inst_valid = 1'b1;
    chk({tag, ".rdy"}, 32'(bus.inst_ready), 32'd1);
    @(posedge clk);
    @(negedge clk);
    bus.inst_valid = 1'b0;
    bus.inst       = 32'hFFFF_FFFF;
    chk({tag, ".busy"}, 32'(bus.inst_ready), 32'd0);
    chk({tag, ".ra"}, 32'(bus.raddra), 32'(ins[25:21]));
    chk({tag, ".rb"}, 32'(bus.raddrb), 32'(ins[20:16]));
    @(negedge clk);
    chk({tag, ".exec"}, 32'({bus.wea, bus.done}), 32'd0);
    @(negedge clk);
    chk({tag, ".done"}, 32'(bus.done), 32'd1);
    chk({tag, ".wea"}, 32'(bus.wea), 32'(rd != 5'd0));
    chk({tag, ".wad"}, 32'(bus.waddra), 32'(rd));
    chk({tag, ".din"}, bus.dina, exp_d);
    chk({tag, ".zf"}, 32'(bus.zf), 32'(exp_z));
    chk({tag, ".of"}, 32'(bus.of), 32'(exp_o));
    @(negedge clk);
    chk({tag, ".idle"},
        32'({bus.done, bus.wea, bus.inst_ready}), 32'd1);
    if (rd != 5'd0) chk({tag, ".rf"}, rf[rd], exp_d);
  endtask

  task automatic illegal_op(input string tag,
                            input logic [31:0] ins,
                            input logic exp_z,
                            input logic exp_o);
    @(negedge clk);
    bus.inst       = ins;
    bus.inst_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.inst_valid = 1'b0;
    chk({tag, ".ill"}, 32'(bus.illegal), 32'd1);
    chk({tag, ".rdy"}, 32'(bus.inst_ready), 32'd1);
    chk({tag, ".flags"}, 32'({bus.zf, bus.of}),
        32'({exp_z, exp_o}));
    chk({tag, ".nodone"}, 32'(bus.done), 32'd0);
    @(negedge clk);
    chk({tag, ".pulse"}, 32'(bus.illegal), 32'd0);
  endtask

  initial begin
    rsta           = 1'b1;
    bus.inst_valid = 1'b0;
    bus.inst       = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst.rdy", 32'(bus.inst_ready), 32'd0);
    chk("rst.flags",
        32'({bus.wea, bus.done, bus.illegal, bus.zf, bus.of}),
        32'd0);
    chk("rst.addr",
        32'({bus.raddra, bus.raddrb, bus.waddra}), 32'd0);
    chk("rst.dina", bus.dina, 32'd0);
    rsta = 1'b0;
    #1 chk("rst.rel", 32'(bus.inst_ready), 32'd1);

    preload(5'd1, 32'd5);
    preload(5'd2, 32'd7);
    exec_op("add", 32'h0022_1820, 32'd12, 1'b0, 1'b0);

    preload(5'd1, 32'h7FFF_FFFF);
    preload(5'd2, 32'h7FFF_FFFF);
    exec_op("subz", 32'h0022_2022, 32'd0, 1'b1, 1'b0);

    preload(5'd1, 32'h8000_0000);
    preload(5'd2, 32'd1);
    exec_op("subo", 32'h0022_2822, 32'h7FFF_FFFF, 1'b0, 1'b1);

    preload(5'd1, 32'h7FFF_FFFF);
    exec_op("addo", 32'h0022_6820, 32'h8000_0000, 1'b0, 1'b1);

    illegal_op("ilop", 32'h8C00_0000, 1'b0, 1'b1);
    illegal_op("ilfn", 32'h0022_1821, 1'b0, 1'b1);

    preload(5'd1, 32'hFFFF_FFFF);
    exec_op("slt", 32'h0022_302A, 32'd1, 1'b0, 1'b0);

    preload(5'd2, 32'h0000_000F);
    exec_op("sll", 32'h0002_3900, 32'h0000_00F0, 1'b0, 1'b0);

    preload(5'd2, 32'h8000_0000);
    exec_op("srl", 32'h0002_47C2, 32'd1, 1'b0, 1'b0);

    preload(5'd1, 32'hF0F0_F0F0);
    preload(5'd2, 32'hFF00_FF00);
    exec_op("and", 32'h0022_4824, 32'hF000_F000, 1'b0, 1'b0);
    exec_op("nor", 32'h0022_5027, 32'h000F_000F, 1'b0, 1'b0);
    exec_op("xor", 32'h0022_5826, 32'h0FF0_0FF0, 1'b0, 1'b0);
    exec_op("or",  32'h0022_6025, 32'hFFF0_FFF0, 1'b0, 1'b0);

    preload(5'd1, 32'd5);
    preload(5'd2, 32'd7);
    exec_op("rd0", 32'h0022_0020, 32'd12, 1'b0, 1'b0);

    // Back-to-back: second op reads R3 written at the prior edge
    preload(5'd3, 32'd0);
    @(negedge clk);
    bus.inst       = 32'h0022_1820;
    bus.inst_valid = 1'b1;
    chk("b2b.rdy0", 32'(bus.inst_ready), 32'd1);
    @(posedge clk);
    @(negedge clk);
    bus.inst = 32'h0063_2020;
    chk("b2b.rd", 32'(bus.inst_ready), 32'd0);
    @(negedge clk);
    chk("b2b.ex", 32'(bus.inst_ready), 32'd0);
    @(negedge clk);
    chk("b2b.wb", 32'(bus.inst_ready), 32'd0);
    chk("b2b.d1", bus.dina, 32'd12);
    @(negedge clk);
    chk("b2b.rdy1", 32'(bus.inst_ready), 32'd1);
    chk("b2b.r3", rf[3], 32'd12);
    @(posedge clk);
    @(negedge clk);
    bus.inst_valid = 1'b0;
    chk("b2b.acc", 32'(bus.inst_ready), 32'd0);
    chk("b2b.ra", 32'(bus.raddra), 32'd3);
    @(negedge clk);
    @(negedge clk);
    chk("b2b.wea", 32'(bus.wea), 32'd1);
    chk("b2b.wad", 32'(bus.waddra), 32'd4);
    chk("b2b.d2", bus.dina, 32'd24);
    @(negedge clk);
    chk("b2b.r4", rf[4], 32'd24);

    // Reset lands in EXEC; the write-back must never happen
    preload(5'd14, 32'hDEAD_BEEF);
    @(negedge clk);
    bus.inst       = 32'h0022_7020;
    bus.inst_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.inst_valid = 1'b0;
    @(negedge clk);
    rsta = 1'b1;
    @(negedge clk);
    rsta = 1'b0;
    #1;
    chk("mid.rdy", 32'(bus.inst_ready), 32'd1);
    chk("mid.flags",
        32'({bus.wea, bus.done, bus.illegal, bus.zf, bus.of}),
        32'd0);
    chk("mid.addr",
        32'({bus.raddra, bus.raddrb, bus.waddra}), 32'd0);
    chk("mid.dina", bus.dina, 32'd0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("mid.quiet", 32'({bus.wea, bus.done}), 32'd0);
    end
    chk("mid.r14", rf[14], 32'hDEAD_BEEF);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/r_type_exec.md
# r_type_exec

Multi-cycle execute/write-back sequencer for the R-type CPU. It accepts one 32-bit MIPS-style R-type instruction per handshake and reads its two source operands from the 32x32 register file through ports `raddra`/`raddrb`. It computes the ALU result, then writes it back through `wea`/`waddra`/`dina`. It sits directly in front of the register file, driving all of the register file's address, data and write-enable inputs and consuming `douta`/`doutb`.

## Interface
- `DATA_W`, 32: operand and result width. Only 32 is supported.
- `ADDR_W`, 5: register address width.

- `clka` in 1: the single clock. All state updates on the rising edge.
- `rsta` in 1: reset. Synchronous, active-high.
- `inst_valid` in 1: an instruction is presented on `inst`.
- `inst` in 32: instruction fields are op[31:26], rs[25:21], rt[20:16], rd[15:11], shamt[10:6], funct[5:0].
- `inst_ready` out 1: the sequencer can accept an instruction.
- `raddra` out ADDR_W: register file read address A (rs).
- `raddrb` out ADDR_W: register file read address B (rt).
- `douta` in DATA_W: register file read data A. This is a combinational read of `raddra`.
- `doutb` in DATA_W: register file read data B. This is a combinational read of `raddrb`.
- `wea` out 1: register file write enable.
- `waddra` out ADDR_W: register file write address (rd).
- `dina` out DATA_W: register file write data.
- `done` out 1: one-cycle pulse that coincides with the write-back cycle.
- `illegal` out 1: one-cycle pulse when an unsupported instruction is rejected.
- `zf` out 1: registered zero flag of the last executed instruction.
- `of` out 1: registered signed-overflow flag of the last executed instruction.

## Operation
- **FSM states:** IDLE, READ, EXEC, WB.
- **IDLE:**
  - `inst_ready` = 1.
  - On `inst_valid` with op == 0 and a supported funct: latch rs/rt/rd/shamt/funct, then go to READ.
  - On `inst_valid` with op != 0 or an unsupported funct: pulse `illegal` for the next cycle and stay in IDLE. Flags and the latched fields are unchanged.
- **READ:**
  - `raddra` = rs and `raddrb` = rt. These are registered from the latch and hold until the next acceptance.
  - Capture `douta` and `doutb` into operand registers A and B, then go to EXEC.
- **EXEC:** compute the result into a result register, update `zf`/`of`, then go to WB.
- **WB:**
  - `waddra` = rd, `dina` = result, `done` = 1.
  - `wea` = 1 unless rd == 0. Register 0 is never written, but `done` still pulses.
  - Then go to IDLE.
- **Supported funct values:**
  - 0x20 ADD: A+B, mod 2^32.
  - 0x22 SUB: A−B, mod 2^32.
  - 0x24 AND, 0x25 OR, 0x26 XOR, 0x27 NOR: bitwise.
  - 0x2A SLT: 1 if A < B as signed values, else 0.
  - 0x00 SLL: B << shamt.
  - 0x02 SRL: B >> shamt, logical.
- **Flags:**
  - `zf` = (result == 0).
  - `of` = signed overflow, for ADD/SUB only. ADD overflows when both operands have the same sign and the result sign differs. SUB overflows when the operands have different signs and the result sign differs from A.
  - `of` = 0 for every other funct.
  - Overflow does not suppress write-back.
- Fields of `inst` are sampled only at the acceptance edge. `inst` may change freely afterwards.

## Timing
- **Acceptance:** the instruction is accepted at edge E0, when the FSM is in IDLE and `inst_valid` && `inst_ready`.
- **Cycle sequence after E0:**
  - READ is the cycle between E0 and E1.
  - EXEC is the cycle between E1 and E2.
  - WB is the cycle between E2 and E3. `wea`/`done` are high during this cycle, and the register file commits at E3.
  - IDLE resumes after E3.
- **Throughput:** one instruction per 4 cycles. `inst_ready` is low during READ, EXEC and WB.
- **Back-to-back operation:** an instruction held valid after E3 is accepted at E4. Its READ cycle therefore sees the value written at E3, so there is no hazard window.
- **Pulse widths:** `illegal` and `done` are exactly one cycle wide.
- **Reset values:** after any edge with `rsta` = 1, the state is IDLE and all of the following are 0: `wea`, `done`, `illegal`, `zf`, `of`, `raddra`, `raddrb`, `waddra`, `dina`, and the operand and result registers.
- **`inst_ready` during reset:** `inst_ready` = (state == IDLE) && !`rsta`, so no instruction is accepted in a reset cycle.
- **Reset mid-operation:** reset during READ, EXEC or WB aborts the instruction. `wea` is 0 in the cycle following the reset edge, and no `done` is issued.

## Test plan
- **ADD:**
  - Stimulus: preload R1 = 5, R2 = 7, then issue `inst` = 0x00221820 (ADD rd=3, rs=1, rt=2).
  - Required response: `wea` = 1, `waddra` = 3 and `dina` = 12 exactly 3 cycles after acceptance; `done` pulses; `zf` = 0; `of` = 0; R3 then reads back 12.
- **SUB with zero and overflow:**
  - Stimulus 1: R1 = R2 = 0x7FFFFFFF, issue SUB rd=4.
  - Required response 1: `dina` = 0, `zf` = 1.
  - Stimulus 2: R1 = 0x80000000, R2 = 1, issue SUB.
  - Required response 2: `dina` = 0x7FFFFFFF, `of` = 1, and the write-back still occurs.
- **SLT and shifts:**
  - SLT with R1 = 0xFFFFFFFF, R2 = 1 -> `dina` = 1.
  - SLL with shamt = 4, rt = 0x0000000F -> `dina` = 0xF0.
  - SRL with shamt = 31, rt = 0x80000000 -> `dina` = 1.
- **Illegal and rd = 0:**
  - `inst` = 0x8C000000 (op != 0) -> `illegal` pulses one cycle, `inst_ready` stays 1, `zf`/`of` unchanged.
  - ADD with rd = 0 -> `done` = 1 with `wea` = 0.
- **Back-to-back dependency:**
  - Hold `inst_valid` high with ADD R3 = R1+R2 followed by ADD R4 = R3+R3 (R1 = 5, R2 = 7).
  - Required response: the second instruction is accepted 4 cycles after the first and writes R4 = 24.
- **Reset mid-operation:**
  - Stimulus: assert `rsta` for one cycle during the EXEC of an ADD.
  - Required response: no `wea` or `done` ever appears for that ADD, all outputs read 0, the target register is unchanged, and `inst_ready` = 1 in the first cycle with `rsta` low.
